// File: rtl/pad_cfg_ctrl.sv
// rtl/pad_cfg_ctrl.sv - pad-ring configuration controller with shadow/active banks and input synchronisers (optional PAD_CFG_LOCK_EN)
module pad_cfg_ctrl #(
   parameter int NUM_INPUT   = 12,
   parameter int NUM_BIDIR   = 42,
   parameter int SYNC_STAGES = 2,
   localparam int NUM_PADS   = NUM_BIDIR + NUM_INPUT,
   localparam int AW_BASE    = $clog2(NUM_PADS),
`ifdef PAD_CFG_LOCK_EN
   localparam int AW         = (((1 << AW_BASE) - 1) < NUM_PADS) ? AW_BASE + 1 : AW_BASE
`else
   localparam int AW         = AW_BASE
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [7:0]           cfg_wdata,
   output logic                 rsp_valid,
   output logic [7:0]           rsp_rdata,
   output logic                 rsp_err,
   input  logic                 commit,
   output logic                 commit_done,
   input  logic [NUM_BIDIR-1:0] core_out,
   input  logic [NUM_BIDIR-1:0] core_oe,
   output logic [NUM_BIDIR-1:0] bidir_a,
   output logic [NUM_BIDIR-1:0] bidir_oe,
   output logic [NUM_BIDIR-1:0] bidir_cs,
   output logic [NUM_BIDIR-1:0] bidir_sl,
   output logic [NUM_BIDIR-1:0] bidir_ie,
   output logic [NUM_BIDIR-1:0] bidir_pu,
   output logic [NUM_BIDIR-1:0] bidir_pd,
   output logic [NUM_INPUT-1:0] input_pu,
   output logic [NUM_INPUT-1:0] input_pd,
   input  logic [NUM_BIDIR-1:0] bidir_pad_in,
   input  logic [NUM_INPUT-1:0] input_pad_in,
   output logic [NUM_BIDIR-1:0] bidir_sync,
   output logic [NUM_INPUT-1:0] input_sync
);

   typedef enum logic {S_IDLE = 1'b0, S_COMMIT = 1'b1} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [7:0] r_shadow_b [NUM_BIDIR];
   logic [7:0] r_active_b [NUM_BIDIR];
   logic [1:0] r_shadow_i [NUM_INPUT];
   logic [1:0] r_active_i [NUM_INPUT];

   logic       r_rsp_valid;
   logic       r_rsp_err;
   logic [7:0] r_rsp_rdata;
   logic       r_commit_done;

   logic [NUM_BIDIR-1:0] r_bsync [SYNC_STAGES];
   logic [NUM_INPUT-1:0] r_isync [SYNC_STAGES];

   logic       w_accept;
   logic       w_in_range;
   logic [7:0] w_rd_data;
   logic       w_wr_en;
   logic       w_locked;
   logic       w_is_lock;
   logic       w_in_commit;

`ifdef PAD_CFG_LOCK_EN
   logic r_lock;
   logic w_lock_set;

   // The lock register sits at the all-ones address, which is always outside the pad range.
   assign w_is_lock  = (cfg_addr == {AW{1'b1}});
   assign w_lock_set = w_accept & cfg_we & w_is_lock & cfg_wdata[0];
   assign w_locked   = r_lock;

   // Sticky lock: only reset releases it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock <= 1'b0;
      end else if (w_lock_set) begin
         r_lock <= 1'b1;
      end
   end
`else
   assign w_is_lock = 1'b0;
   assign w_locked  = 1'b0;
`endif

   assign w_accept    = cfg_valid & cfg_ready;
   assign w_wr_en     = w_accept & cfg_we & w_in_range & ~w_locked;
   assign w_in_commit = (r_state == S_COMMIT);

   // Address decode and shadow read mux.
   always_comb begin
      w_in_range = 1'b0;
      w_rd_data  = 8'h00;
      for (int i = 0; i < NUM_BIDIR; i++) begin
         if (cfg_addr == AW'(i)) begin
            w_in_range = 1'b1;
            w_rd_data  = r_shadow_b[i];
         end
      end
      for (int i = 0; i < NUM_INPUT; i++) begin
         if (cfg_addr == AW'(NUM_BIDIR + i)) begin
            w_in_range = 1'b1;
            w_rd_data  = {6'b000000, r_shadow_i[i]};
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; requests are only taken while idle, so a same-cycle write lands before the copy.
   always_comb begin
      w_state_nxt = r_state;
      cfg_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            cfg_ready = 1'b1;
            if (commit && !w_locked) begin
               w_state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Shadow bank: written by accepted in-range writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BIDIR; i++) r_shadow_b[i] <= 8'h10;
         for (int i = 0; i < NUM_INPUT; i++) r_shadow_i[i] <= 2'b00;
      end else if (w_wr_en) begin
         for (int i = 0; i < NUM_BIDIR; i++) begin
            if (cfg_addr == AW'(i)) r_shadow_b[i] <= cfg_wdata;
         end
         for (int i = 0; i < NUM_INPUT; i++) begin
            if (cfg_addr == AW'(NUM_BIDIR + i)) r_shadow_i[i] <= cfg_wdata[1:0];
         end
      end
   end

   // Active bank: whole-bank copy on the commit edge so every pad changes together.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BIDIR; i++) r_active_b[i] <= 8'h10;
         for (int i = 0; i < NUM_INPUT; i++) r_active_i[i] <= 2'b00;
      end else if (w_in_commit) begin
         for (int i = 0; i < NUM_BIDIR; i++) r_active_b[i] <= r_shadow_b[i];
         for (int i = 0; i < NUM_INPUT; i++) r_active_i[i] <= r_shadow_i[i];
      end
   end

   // Response and commit-done pulses, one cycle after the triggering edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_rdata   <= 8'h00;
         r_commit_done <= 1'b0;
      end else begin
         r_rsp_valid   <= w_accept;
         r_rsp_err     <= 1'b0;
         r_rsp_rdata   <= 8'h00;
         r_commit_done <= w_in_commit;
         if (w_accept) begin
            if (w_is_lock) begin
               r_rsp_err   <= cfg_we & w_locked;
               r_rsp_rdata <= cfg_we ? 8'h00 : {7'b0000000, w_locked};
            end else if (!w_in_range) begin
               r_rsp_err <= 1'b1;
            end else if (cfg_we) begin
               r_rsp_err <= w_locked;
            end else begin
               r_rsp_rdata <= w_rd_data;
            end
         end
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_err     = r_rsp_err;
   assign rsp_rdata   = r_rsp_rdata;
   assign commit_done = r_commit_done;

   // Pad controls from the active bank; PU and PD together would fight, so both are dropped.
   always_comb begin
      bidir_a  = '0;
      bidir_oe = '0;
      bidir_cs = '0;
      bidir_sl = '0;
      bidir_ie = '0;
      bidir_pu = '0;
      bidir_pd = '0;
      input_pu = '0;
      input_pd = '0;
      for (int i = 0; i < NUM_BIDIR; i++) begin
         bidir_oe[i] = r_active_b[i][7] ? core_oe[i]  : r_active_b[i][0];
         bidir_a[i]  = r_active_b[i][7] ? core_out[i] : r_active_b[i][1];
         bidir_cs[i] = r_active_b[i][2];
         bidir_sl[i] = r_active_b[i][3];
         bidir_ie[i] = r_active_b[i][4];
         bidir_pu[i] = r_active_b[i][5] & ~r_active_b[i][6];
         bidir_pd[i] = r_active_b[i][6] & ~r_active_b[i][5];
      end
      for (int i = 0; i < NUM_INPUT; i++) begin
         input_pu[i] = r_active_i[i][0] & ~r_active_i[i][1];
         input_pd[i] = r_active_i[i][1] & ~r_active_i[i][0];
      end
   end

   // Pad-to-core synchroniser chains.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_bsync[s] <= '0;
            r_isync[s] <= '0;
         end
      end else begin
         r_bsync[0] <= bidir_pad_in;
         r_isync[0] <= input_pad_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_bsync[s] <= r_bsync[s-1];
            r_isync[s] <= r_isync[s-1];
         end
      end
   end

   assign bidir_sync = r_bsync[SYNC_STAGES-1];
   assign input_sync = r_isync[SYNC_STAGES-1];

endmodule

// File: doc/pad_cfg_ctrl.md
Name: pad_cfg_ctrl

Overview:
Run-time pad-ring configuration controller between chip_core and the pad instances in chip_top. It holds a per-pad configuration register for every bidir pad (OE, A, CS, SL, IE, PU, PD, FUNC) and every input pad (PU, PD), written through a valid/ready port into a shadow bank. A commit transfers the shadow bank to the active bank so all pads reconfigure on the same edge. It also synchronises all pad-to-core inputs.

Parameters:
NUM_INPUT, 12, number of input-only pads
NUM_BIDIR, 42, number of bidirectional pads
SYNC_STAGES, 2, synchroniser depth on pad inputs (legal 2..4)
AW, $clog2(NUM_BIDIR+NUM_INPUT), config address width (derived; not overridden)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  request valid
cfg_ready  out  1  request accepted when valid&ready
cfg_we  in  1  1=write, 0=read
cfg_addr  in  AW  pad index: 0..NUM_BIDIR-1 bidir, NUM_BIDIR..NUM_BIDIR+NUM_INPUT-1 input
cfg_wdata  in  8  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  8  read data (shadow bank); 0 for writes
rsp_err  out  1  out-of-range address, valid with rsp_valid
commit  in  1  request shadow->active copy
commit_done  out  1  one-cycle pulse when active bank updated
core_out  in  NUM_BIDIR  functional output data from core
core_oe  in  NUM_BIDIR  functional output enable from core
bidir_a, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd  out  NUM_BIDIR each  to bidir pads
input_pu, input_pd  out  NUM_INPUT each  to input pads
bidir_pad_in  in  NUM_BIDIR  raw pad Y
input_pad_in  in  NUM_INPUT  raw pad Y
bidir_sync  out  NUM_BIDIR  synchronised bidir inputs
input_sync  out  NUM_INPUT  synchronised input-pad inputs

Behaviour:
- Bidir cfg byte: [0]OE [1]A [2]CS [3]SL [4]IE [5]PU [6]PD [7]FUNC. Input cfg byte: [0]PU [1]PD, [7:2] read 0, writes ignored.
- Reset (rst sampled high at clk): shadow and active bidir = 8'h10, input = 8'h00. Outputs: bidir_ie all 1, all other pad controls 0. cfg_ready 1, rsp_valid/rsp_err/rsp_rdata/commit_done 0, sync chains 0. Reset mid-transaction or mid-commit aborts it with no response and no commit_done.
- FSM IDLE/COMMIT. IDLE: cfg_ready=1. In COMMIT: cfg_ready=0, active<=shadow, commit_done=1 on the next cycle, return to IDLE.
- IDLE with commit=1 goes to COMMIT. If cfg_valid and commit are both high in IDLE, the request is accepted first, its write lands in shadow on that edge, and the following commit includes it.
- A transfer is accepted on valid&ready. rsp_valid pulses exactly 1 cycle after acceptance. Back-to-back transfers are allowed at 1 per cycle.
- Out of range (addr >= NUM_BIDIR+NUM_INPUT): no state change, rsp_err=1, rsp_rdata=0.
- Read returns the shadow value, with writes visible to the very next read. Active is not readable.
- Pad outputs are registered from the active bank, so the change appears the cycle commit_done is high.
- FUNC=1: bidir_a=core_out[i], bidir_oe=core_oe[i] (combinational from core). FUNC=0: bidir_a and bidir_oe come from cfg bits [1] and [0].
- PU&PD both 1 in the active bank: driven PU=PD=0. Raw bits are kept and read back unchanged.
- Synchronisers: SYNC_STAGES flops per bit, latency exactly SYNC_STAGES cycles.

Optional Feature:
PAD_CFG_LOCK_EN. When defined, address 2^AW-1 is a lock register if it lies outside the pad range; otherwise AW is widened by 1.
- Writing bit0=1 sets the lock. It clears only on rst.
- While locked: cfg writes are ignored with rsp_err=1, commit is ignored (no commit_done), and reads still work.
- Without the macro, that address is ordinary out-of-range.

Test Plan:
- Reset: after rst, bidir_ie=all 1, bidir_oe/pu/pd=0, read addr 0 gives 8'h10, read addr NUM_BIDIR gives 8'h00.
- Write 8'h03 to addr 5, no commit: bidir_oe[5] stays 0 and reading addr 5 gives 8'h03. Then pulse commit: commit_done 2 cycles later, same cycle bidir_oe[5]=1 and bidir_a[5]=1.
- Write 8'h60 to addr 7 (PU+PD), commit: bidir_pu[7]=bidir_pd[7]=0, read gives 8'h60.
- Write 8'h80 to addr 3, commit, core_oe[3]=1, core_out[3] toggling: bidir_oe[3]=1 and bidir_a[3] tracks core_out[3].
- cfg_valid write 8'h01 to addr 0 together with commit in IDLE: cfg_ready low the next cycle, bidir_oe[0]=1 at commit_done. Read addr 54: rsp_err=1, rdata=0.
- input_pad_in[2] 0->1: input_sync[2] rises exactly SYNC_STAGES cycles later. Assert rst during COMMIT: no commit_done, outputs at reset values.
